alu_cmd_issue: RTL and testbench

- Command front-end that sits directly upstream of the combinational 32-bit ALU and consumes its result.
- Buffers operand/opcode commands in a small FIFO and issues one command at a time on the ALU operand ports.
- Captures the ALU result one cycle after issue and presents it on a valid/ready result port.
- Screens illegal operations (divide/modulo by zero, reserved opcodes): returns result 0 with an error flag and counts the events.

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_cmd_fifo.sv | 55 +++++
 rtl/alu_cmd_issue.sv | 163 ++++++++++++++++
 tb/tb_alu_cmd_issue.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Opcode encodings, issue FSM states and illegal-op screening
//               shared by the ALU command front-end.
// Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_DIV  = 3'b011;
    localparam logic [2:0] OP_POW  = 3'b100;
    localparam logic [2:0] OP_MOD  = 3'b101;
    localparam logic [2:0] OP_RSV0 = 3'b110;
    localparam logic [2:0] OP_RSV1 = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Operands up to this width can be screened; callers zero-extend b.
    localparam int unsigned OPND_MAX_W = 64;

    function automatic logic is_illegal(input logic [2:0]            oper,
                                        input logic [OPND_MAX_W-1:0] b);
        logic w_zero_div;
        w_zero_div = ((oper == OP_DIV) || (oper == OP_MOD)) && (b == '0);
        return w_zero_div || (oper == OP_RSV0) || (oper == OP_RSV1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : alu_cmd_fifo
// Description : Synchronous FIFO holding packed ALU commands; head is
//               presented combinationally, pointers wrap modulo DEPTH.
// Revision    : 1.0  initial release
// ============================================================================
module alu_cmd_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic [DW-1:0] i_data,
    input  logic          i_pop,
    output logic [DW-1:0] o_data,
    output logic          o_full,
    output logic          o_empty,
    output logic [AW:0]   o_count
);
    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once the count says so.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/alu_cmd_issue.sv
`default_nettype none
// ============================================================================
// Module      : alu_cmd_issue
// Description : Buffers ALU commands, issues one at a time to an external
//               combinational ALU and returns screened results on valid/ready.
// Revision    : 1.0  initial release
// ============================================================================
module alu_cmd_issue
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [2:0]       cmd_oper,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_oper,
    input  logic [WIDTH-1:0] alu_y,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic [TAG_W-1:0] res_tag,
    output logic             res_err,
    output logic [7:0]       err_cnt,
    output logic             busy
);
    localparam int CW = 2*WIDTH + 3 + TAG_W;

    logic                   w_full;
    logic                   w_empty;
    logic [$clog2(DEPTH):0] w_count;
    logic                   w_push;
    logic                   w_load;
    logic                   w_res_drop;
    logic                   w_illegal;
    logic [CW-1:0]          w_head;
    logic [WIDTH-1:0]       w_head_a;
    logic [WIDTH-1:0]       w_head_b;
    logic [2:0]             w_head_oper;
    logic [TAG_W-1:0]       w_head_tag;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [WIDTH-1:0]       r_alu_a;
    logic [WIDTH-1:0]       r_alu_b;
    logic [2:0]             r_alu_oper;
    logic [TAG_W-1:0]       r_iss_tag;
    logic                   r_res_valid;
    logic [WIDTH-1:0]       r_res_data;
    logic [TAG_W-1:0]       r_res_tag;
    logic                   r_res_err;
    logic [7:0]             r_err_cnt;

    assign cmd_ready = rst_n & ~w_full;
    assign w_push    = cmd_valid & cmd_ready;

    alu_cmd_fifo #(
        .DW    (CW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  ({cmd_a, cmd_b, cmd_oper, cmd_tag}),
        .i_pop   (w_load),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign {w_head_a, w_head_b, w_head_oper, w_head_tag} = w_head;

    assign w_illegal = is_illegal(r_alu_oper, OPND_MAX_W'(r_alu_b));

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // A DONE handshake with work queued reloads immediately, giving the
    // single-cycle res_valid gap between back-to-back results.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_res_drop  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: w_state_nxt = ST_DONE;
            ST_DONE: begin
                if (r_res_valid && res_ready) begin
                    w_res_drop = 1'b1;
                    if (!w_empty) begin
                        w_load      = 1'b1;
                        w_state_nxt = ST_EXEC;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_oper  <= '0;
            r_iss_tag   <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_tag   <= '0;
            r_res_err   <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            if (w_load) begin
                r_alu_a    <= w_head_a;
                r_alu_b    <= w_head_b;
                r_alu_oper <= w_head_oper;
                r_iss_tag  <= w_head_tag;
            end
            if (w_res_drop) r_res_valid <= 1'b0;
            if (r_state == ST_EXEC) begin
                r_res_valid <= 1'b1;
                r_res_tag   <= r_iss_tag;
                if (w_illegal) begin
                    r_res_data <= '0;
                    r_res_err  <= 1'b1;
                    if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
                end else begin
                    r_res_data <= alu_y;
                    r_res_err  <= 1'b0;
                end
            end
        end
    end

    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_oper  = r_alu_oper;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_tag   = r_res_tag;
    assign res_err   = r_res_err;
    assign err_cnt   = r_err_cnt;
    assign busy      = (w_count != '0) || (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_issue.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_cmd_issue
// Description : Self-checking bench for alu_cmd_issue with an attached ALU
//               stub and a queue-based result model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_alu_cmd_issue;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic [2:0]  cmd_oper;
    logic [3:0]  cmd_tag;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_oper;
    logic [31:0] alu_y;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic [3:0]  res_tag;
    logic        res_err;
    logic [7:0]  err_cnt;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  t;
        logic        e;
    } exp_t;

    exp_t        q[$];
    logic [31:0] got_d[$];
    logic [3:0]  got_t[$];
    logic        got_e[$];
    int          model_err = 0;
    logic        held_v = 1'b0;
    logic [31:0] h_d;
    logic [3:0]  h_t;
    logic        h_e;

    alu_cmd_issue #(.WIDTH(32), .DEPTH(4), .TAG_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_oper  (cmd_oper),
        .cmd_tag   (cmd_tag),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_oper  (alu_oper),
        .alu_y     (alu_y),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_tag   (res_tag),
        .res_err   (res_err),
        .err_cnt   (err_cnt),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Stand-in for the external ALU; garbage on illegal ops so screening matters.
    always_comb begin
        case (alu_oper)
            3'd0:    alu_y = alu_a + alu_b;
            3'd1:    alu_y = alu_a - alu_b;
            3'd2:    alu_y = alu_a * alu_b;
            3'd3:    alu_y = (alu_b == 32'd0) ? 32'hDEADBEEF : alu_a / alu_b;
            3'd4:    alu_y = alu_a ** alu_b;
            3'd5:    alu_y = (alu_b == 32'd0) ? 32'hBADC0DE5 : alu_a % alu_b;
            default: alu_y = alu_a ^ alu_b ^ 32'h5A5A5A5A;
        endcase
    end

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic [2:0] op, input logic [3:0] t);
        exp_t        r;
        logic [63:0] wide;
        logic [31:0] p;
        r.t = t;
        r.e = 1'b0;
        r.d = 32'd0;
        case (op)
            3'd0: begin wide = {32'd0, a} + {32'd0, b}; r.d = wide[31:0]; end
            3'd1: r.d = a - b;
            3'd2: begin wide = {32'd0, a} * {32'd0, b}; r.d = wide[31:0]; end
            3'd3: if (b == 32'd0) r.e = 1'b1; else r.d = a / b;
            3'd4: begin
                p = 32'd1;
                for (int unsigned i = 0; i < b; i++) p = p * a;
                r.d = p;
            end
            3'd5: if (b == 32'd0) r.e = 1'b1; else r.d = a % b;
            default: r.e = 1'b1;
        endcase
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s got timeout expected progress", name);
    endtask

    // Monitor: commands accepted feed the model queue; handshaken results are
    // compared in order, and stalled results must not move.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            model_err = 0;
            held_v    = 1'b0;
        end else begin
            if (res_valid && held_v) begin
                chk("hold_data", res_data, h_d);
                chk("hold_tag", res_tag, h_t);
                chk("hold_err", res_err, h_e);
            end
            held_v = res_valid && !res_ready;
            h_d = res_data;
            h_t = res_tag;
            h_e = res_err;
            if (res_valid && res_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL res_unexpected got tag %0h expected none", res_tag);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("res_data", res_data, e.d);
                    chk("res_tag", res_tag, e.t);
                    chk("res_err", res_err, e.e);
                    if (e.e && model_err != 255) model_err++;
                    chk("err_cnt", err_cnt, model_err);
                    got_d.push_back(res_data);
                    got_t.push_back(res_tag);
                    got_e.push_back(res_err);
                end
            end
            if (cmd_valid && cmd_ready)
                q.push_back(model(cmd_a, cmd_b, cmd_oper, cmd_tag));
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] op, input logic [3:0] tag, input int budget);
        int n = 0;
        bit ok = 1'b0;
        cmd_a = a; cmd_b = b; cmd_oper = op; cmd_tag = tag; cmd_valid = 1'b1;
        while (!ok && n < budget) begin
            @(negedge clk);
            if (cmd_ready) ok = 1'b1;
            n++;
        end
        if (ok) begin
            @(posedge clk);
            #1;
            cmd_valid = 1'b0;
        end else begin
            cmd_valid = 1'b0;
            fail_now("send_accept");
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((q.size() != 0 || busy) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= budget) fail_now("drain");
    endtask

    task automatic clear_got();
        got_d.delete();
        got_t.delete();
        got_e.delete();
    endtask

    initial begin
        logic [31:0] sweep_exp [6];
        sweep_exp = '{32'd12, 32'd8, 32'd20, 32'd5, 32'd100, 32'd0};
        rst_n = 1'b0; cmd_valid = 1'b0; res_ready = 1'b1;
        cmd_a = '0; cmd_b = '0; cmd_oper = '0; cmd_tag = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_res_valid", res_valid, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        rst_n = 1'b1;
        #1;
        chk("cmd_ready_after_rst", cmd_ready, 1);

        // Op sweep with first-result latency
        clear_got();
        send(32'd10, 32'd2, OP_ADD, 4'd0, 4);
        @(negedge clk); chk("lat_valid_t0", res_valid, 0);
        @(negedge clk); chk("lat_valid_t1", res_valid, 0);
        chk("issue_a", alu_a, 10);
        chk("issue_oper", alu_oper, 0);
        @(negedge clk); chk("lat_valid_t2", res_valid, 1);
        @(posedge clk); #1;
        for (int i = 1; i < 6; i++) send(32'd10, 32'd2, 3'(i), 4'(i), 10);
        drain(50);
        chk("sweep_count", got_d.size(), 6);
        for (int i = 0; i < 6 && i < got_d.size(); i++) begin
            chk("sweep_lit_data", got_d[i], sweep_exp[i]);
            chk("sweep_lit_tag", got_t[i], i);
            chk("sweep_lit_err", got_e[i], 0);
        end

        // Illegal operations
        clear_got();
        send(32'd10, 32'd0, OP_DIV, 4'd1, 10);
        send(32'd10, 32'd0, OP_MOD, 4'd2, 10);
        send(32'd7,  32'd3, OP_RSV0, 4'd3, 10);
        send(32'd10, 32'd2, OP_MUL, 4'd4, 10);
        drain(50);
        chk("ill_count", got_d.size(), 4);
        if (got_d.size() == 4) begin
            chk("ill_div_data", got_d[0], 0);
            chk("ill_div_err", got_e[0], 1);
            chk("ill_mod_err", got_e[1], 1);
            chk("ill_rsv_data", got_d[2], 0);
            chk("ill_rsv_err", got_e[2], 1);
            chk("ill_after_data", got_d[3], 20);
            chk("ill_after_err", got_e[3], 0);
        end
        chk("ill_err_cnt", err_cnt, 3);

        // Backpressure: five accepts, sixth blocked until results drain
        clear_got();
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(32'(i + 1), 32'd1, OP_ADD, 4'(i), 1);
        cmd_a = 32'd6; cmd_b = 32'd1; cmd_oper = OP_ADD; cmd_tag = 4'd5; cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_cmd_ready", cmd_ready, 0);
            chk("bp_res_valid", res_valid, 1);
        end
        @(posedge clk); #1;
        res_ready = 1'b1;
        send(32'd6, 32'd1, OP_ADD, 4'd5, 10);
        drain(60);
        chk("bp_count", got_d.size(), 6);
        if (got_d.size() == 6) begin
            chk("bp_first_data", got_d[0], 2);
            chk("bp_last_data", got_d[5], 7);
            chk("bp_last_tag", got_t[5], 5);
        end

        // Simultaneous push and pop at FIFO count 2
        clear_got();
        res_ready = 1'b0;
        send(32'd1, 32'd1, OP_ADD, 4'd10, 4);
        send(32'd2, 32'd1, OP_ADD, 4'd11, 4);
        send(32'd3, 32'd1, OP_ADD, 4'd12, 4);
        chk("pp_count_before", dut.u_fifo.o_count, 2);
        chk("pp_in_done", res_valid, 1);
        res_ready = 1'b1;
        send(32'd4, 32'd1, OP_ADD, 4'd13, 1);
        chk("pp_count_after", dut.u_fifo.o_count, 2);
        drain(50);
        chk("pp_count", got_t.size(), 4);
        for (int i = 0; i < 4 && i < got_t.size(); i++) chk("pp_tag", got_t[i], 10 + i);

        // Reset while DONE with three queued
        clear_got();
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(32'd9, 32'd9, OP_SUB, 4'(i), 4);
        chk("rm_valid_before", res_valid, 1);
        rst_n = 1'b0;
        @(negedge clk); chk("rm_cmd_ready_low", cmd_ready, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rm_res_valid", res_valid, 0);
        chk("rm_res_data", res_data, 0);
        chk("rm_res_tag", res_tag, 0);
        chk("rm_res_err", res_err, 0);
        chk("rm_alu_a", alu_a, 0);
        chk("rm_alu_b", alu_b, 0);
        chk("rm_alu_oper", alu_oper, 0);
        chk("rm_err_cnt", err_cnt, 0);
        chk("rm_busy", busy, 0);
        res_ready = 1'b1;
        send(32'd10, 32'd2, OP_ADD, 4'd7, 4);
        drain(30);
        chk("rm_new_count", got_d.size(), 1);
        if (got_d.size() == 1) chk("rm_new_data", got_d[0], 12);

        // Error counter saturation
        for (int i = 0; i < 260; i++) send(32'(i), 32'd0, OP_DIV, 4'(i), 10);
        drain(50);
        chk("sat_err_cnt", err_cnt, 255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
